// File: rtl/eeg_serial_frame_tx_pkg.sv
// Shared types and widths for the EEG bit-serial frame transmitter.
// The frame width matches the 18-bit NEXTOUT frame of the capture path.
package eeg_serial_frame_tx_pkg;

  localparam int unsigned FRAME_W   = 18;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned BIT_CNT_W = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } tx_state_e;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeg_sync_fifo.sv
// Single-clock word FIFO with show-ahead read data and wrap-bit pointers.
// Pushes while full and pops while empty are ignored.
module eeg_sync_fifo
  import eeg_serial_frame_tx_pkg::*;
#(
  parameter int unsigned WIDTH = FRAME_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [cnt_width(DEPTH):0]  count_o
);

  localparam int unsigned AW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/eeg_serial_frame_tx.sv
// Bit-serial frame transmitter: FIFO-fed words shifted MSB-first on nextout,
// with a generated bit clock (fdata) and a first-bit frame marker (read_strb).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | divider stopped, fdata/nextout/read_strb low
// ST_WAIT  | divider running, waiting for a word at the next tick_fall
// ST_SHIFT | frame on the wire, one bit per fdata period
module eeg_serial_frame_tx
  import eeg_serial_frame_tx_pkg::*;
#(
  parameter int unsigned      WORD_W           = FRAME_W,
  parameter int unsigned      CLK_DIV          = 16,
  parameter int unsigned      FIFO_DEPTH       = 16,
  parameter logic [CNT_W-1:0] FRAME_CNT_RST    = '0,
  parameter logic [CNT_W-1:0] UNDERRUN_CNT_RST = '0
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              fdata,
  output logic              nextout,
  output logic              read_strb,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  underrun_cnt
);

  localparam int unsigned DIV_W  = cnt_width(CLK_DIV);
  localparam int unsigned BCNT_W = cnt_width(WORD_W);
  localparam int unsigned AW     = cnt_width(FIFO_DEPTH);

  tx_state_e          state_q;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               fdata_q, fdata_d;
  logic [WORD_W-1:0]  shreg_q;
  logic [BCNT_W-1:0]  bit_cnt_q;
  logic               read_strb_q;
  logic               busy_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic [CNT_W-1:0]   underrun_cnt_q;
  logic               rdy_q;

  logic               div_tc, tick_fall;
  logic               fifo_push, frame_start;
  logic               fifo_full, fifo_empty;
  logic [WORD_W-1:0]  fifo_rdata;
  logic [AW:0]        fifo_level_unused;

  eeg_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .wdata_i (s_data),
    .pop_i   (frame_start),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_level_unused)
  );

  // rdy_q keeps s_ready low while reset is asserted.
  assign s_ready   = rdy_q && !fifo_full;
  assign fifo_push = s_valid && s_ready;

  // tick_fall is the only point where wire-side outputs may change, leaving
  // a half bit period of setup before the receiver's fdata rising edge.
  assign div_tc    = (state_q != ST_IDLE) && (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign tick_fall = div_tc && fdata_q;

  assign frame_start = tick_fall && enable && !fifo_empty &&
                       ((state_q == ST_WAIT) ||
                        ((state_q == ST_SHIFT) && (bit_cnt_q == '0)));

  always_comb begin
    div_cnt_d = div_cnt_q;
    fdata_d   = fdata_q;
    if (state_q == ST_IDLE) begin
      div_cnt_d = '0;
      fdata_d   = 1'b0;
    end else if (div_tc) begin
      div_cnt_d = '0;
      fdata_d   = ~fdata_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      fdata_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      fdata_q   <= fdata_d;
      rdy_q     <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      read_strb_q    <= 1'b0;
      busy_q         <= 1'b0;
      frame_cnt_q    <= FRAME_CNT_RST;
      underrun_cnt_q <= UNDERRUN_CNT_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tick_fall) begin
            if (!enable) begin
              state_q <= ST_IDLE;
            end else if (frame_start) begin
              state_q     <= ST_SHIFT;
              shreg_q     <= fifo_rdata;
              bit_cnt_q   <= BCNT_W'(WORD_W - 1);
              read_strb_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (tick_fall) begin
            if (bit_cnt_q != '0) begin
              shreg_q     <= {shreg_q[WORD_W-2:0], 1'b0};
              bit_cnt_q   <= bit_cnt_q - 1'b1;
              read_strb_q <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
              if (frame_start) begin
                shreg_q     <= fifo_rdata;
                bit_cnt_q   <= BCNT_W'(WORD_W - 1);
                read_strb_q <= 1'b1;
              end else begin
                shreg_q     <= '0;
                read_strb_q <= 1'b0;
                busy_q      <= 1'b0;
                if (!enable) begin
                  state_q <= ST_IDLE;
                end else begin
                  state_q <= ST_WAIT;
                  if (underrun_cnt_q != '1) underrun_cnt_q <= underrun_cnt_q + 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fdata        = fdata_q;
  assign nextout      = shreg_q[WORD_W-1];
  assign read_strb    = read_strb_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule
